// File: rtl/serial_addsub_if.sv
// Operand/result bundle for serial_addsub: the requester drives the master side,
// the adder/subtractor implements the slave side.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic             SUB;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] S;
  logic             COUT;
  logic             OVF;

  modport master (
    output START, SUB, A, B, CIN,
    input  BUSY, DONE, S, COUT, OVF
  );

  modport slave (
    input  START, SUB, A, B, CIN,
    output BUSY, DONE, S, COUT, OVF
  );
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: STEP bits per clock, LSB first, through a chain
// of STEP full-adder cells with a registered carry between slices.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic          CLK,
  input  logic          RST,
  serial_addsub_if.slave bus
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_params
      $error("serial_addsub: WIDTH must be >= 2 and an exact multiple of STEP");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [STEP-1:0]  slice_sum;
  logic             slice_cout;
  logic             slice_cmsb;
  logic             last_slice;

  assign last_slice = (cnt_q == CW'(N - 1));

  // State register and all datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic; FIN accepts a new request directly for back-to-back use.
  always_comb begin
    // NOTE: a default before any branch keeps combinational blocks latch-free.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.START) state_d = RUN;
      RUN:     if (last_slice) state_d = FIN;
      FIN:     state_d = bus.START ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from state.
  always_comb begin
    bus.BUSY = (state_q == RUN);
    bus.DONE = (state_q == FIN);
  end

  assign bus.S    = s_q;
  assign bus.COUT = cout_q;
  assign bus.OVF  = ovf_q;

  // Ripple chain across the current slice; slice_cmsb is the carry into the
  // top cell, which on the last slice is the carry into the word MSB.
  always_comb begin
    logic c;
    slice_sum  = '0;
    slice_cmsb = 1'b0;
    c          = carry_q;
    for (int i = 0; i < STEP; i++) begin
      slice_sum[i] = a_q[i] ^ b_q[i] ^ c;
      if (i == STEP - 1) slice_cmsb = c;
      c = ((a_q[i] ^ b_q[i]) & c) | (a_q[i] & b_q[i]);
    end
    slice_cout = c;
  end

  // Operand capture, slice shifting and result publication.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    if (state_q == RUN) begin
      a_d                    = a_q >> STEP;
      b_d                    = b_q >> STEP;
      acc_d                  = acc_q >> STEP;
      acc_d[WIDTH-1 -: STEP] = slice_sum;
      carry_d                = slice_cout;
      cnt_d                  = cnt_q + CW'(1);
      if (last_slice) begin
        s_d    = acc_d;
        cout_d = slice_cout;
        ovf_d  = slice_cmsb ^ slice_cout;
      end
    end else if (bus.START) begin
      // Subtraction is A + ~B with the carry-in inverted.
      a_d     = bus.A;
      b_d     = bus.B ^ {WIDTH{bus.SUB}};
      carry_d = bus.CIN ^ bus.SUB;
      cnt_d   = '0;
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: four configurations (8/1, 8/4, 4/1, 4/2)
// checked against an integer-arithmetic reference model.
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_r, sub_r, cin_r;
  logic [7:0] a_r, b_r;
  int         sel_r;
  int         cur_sel;

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8)) if81 ();
  serial_addsub_if #(.WIDTH(8)) if84 ();
  serial_addsub_if #(.WIDTH(4)) if41 ();
  serial_addsub_if #(.WIDTH(4)) if42 ();

  assign if81.START = start_r && (sel_r == 0);
  assign if84.START = start_r && (sel_r == 1);
  assign if41.START = start_r && (sel_r == 2);
  assign if42.START = start_r && (sel_r == 3);
  assign if81.SUB = sub_r;   assign if84.SUB = sub_r;
  assign if41.SUB = sub_r;   assign if42.SUB = sub_r;
  assign if81.CIN = cin_r;   assign if84.CIN = cin_r;
  assign if41.CIN = cin_r;   assign if42.CIN = cin_r;
  assign if81.A = a_r;       assign if84.A = a_r;
  assign if41.A = a_r[3:0];  assign if42.A = a_r[3:0];
  assign if81.B = b_r;       assign if84.B = b_r;
  assign if41.B = b_r[3:0];  assign if42.B = b_r[3:0];

  serial_addsub #(.WIDTH(8), .STEP(1)) dut81 (.CLK(clk), .RST(rst), .bus(if81));
  serial_addsub #(.WIDTH(8), .STEP(4)) dut84 (.CLK(clk), .RST(rst), .bus(if84));
  serial_addsub #(.WIDTH(4), .STEP(1)) dut41 (.CLK(clk), .RST(rst), .bus(if41));
  serial_addsub #(.WIDTH(4), .STEP(2)) dut42 (.CLK(clk), .RST(rst), .bus(if42));

  logic       busy_w [4];
  logic       done_w [4];
  logic       cout_w [4];
  logic       ovf_w  [4];
  logic [7:0] s_w    [4];

  assign busy_w[0] = if81.BUSY;  assign busy_w[1] = if84.BUSY;
  assign busy_w[2] = if41.BUSY;  assign busy_w[3] = if42.BUSY;
  assign done_w[0] = if81.DONE;  assign done_w[1] = if84.DONE;
  assign done_w[2] = if41.DONE;  assign done_w[3] = if42.DONE;
  assign cout_w[0] = if81.COUT;  assign cout_w[1] = if84.COUT;
  assign cout_w[2] = if41.COUT;  assign cout_w[3] = if42.COUT;
  assign ovf_w[0]  = if81.OVF;   assign ovf_w[1]  = if84.OVF;
  assign ovf_w[2]  = if41.OVF;   assign ovf_w[3]  = if42.OVF;
  assign s_w[0]    = if81.S;     assign s_w[1]    = if84.S;
  assign s_w[2]    = {4'h0, if41.S};
  assign s_w[3]    = {4'h0, if42.S};

  int         errors = 0;
  int         checks = 0;
  int         n_of [4] = '{8, 2, 4, 2};
  int         w_of [4] = '{8, 8, 4, 4};
  logic [7:0] prev_s [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d: got %0h expected %0h", tag, cur_sel, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input int w, input bit sub, input int a, input int b,
                                input bit cin, output logic [7:0] s, output logic cout,
                                output logic ovf);
    int m, tot, sa, sb, sr;
    m   = 1 << w;
    a   = a % m;
    b   = b % m;
    tot = sub ? (a - b - int'(cin) + m) : (a + b + int'(cin));
    s   = 8'(tot % m);
    cout = (tot >= m);
    sa  = (a >= m / 2) ? a - m : a;
    sb  = (b >= m / 2) ? b - m : b;
    sr  = sub ? (sa - sb - int'(cin)) : (sa + sb + int'(cin));
    ovf = (sr < -(m / 2)) || (sr > (m / 2) - 1);
  endfunction

  // Called at a falling edge; operands are scrambled after capture.
  task automatic launch(input int sel, input bit sub, input int a, input int b, input bit cin);
    cur_sel = sel;
    sel_r   = sel;
    sub_r   = sub;
    a_r     = a[7:0];
    b_r     = b[7:0];
    cin_r   = cin;
    start_r = 1'b1;
    @(posedge clk);
    #1;
    start_r = 1'b0;
    a_r     = 8'($urandom);
    b_r     = 8'($urandom);
    sub_r   = 1'($urandom);
    cin_r   = 1'($urandom);
  endtask

  // Returns at the falling edge where DONE is high.
  task automatic wait_done(input int sel, input int exp_busy, input logic [7:0] es,
                           input bit ec, input bit eo);
    int nb;
    bit seen;
    nb   = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done_w[sel]) seen = 1'b1;
      else begin
        if (busy_w[sel]) nb++;
        check("s_hold", {24'h0, s_w[sel]}, {24'h0, prev_s[sel]});
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("busy_cycles", nb, exp_busy);
    check("busy_at_done", 32'(busy_w[sel]), 32'd0);
    check("s", {24'h0, s_w[sel]}, {24'h0, es});
    check("cout", 32'(cout_w[sel]), 32'(ec));
    check("ovf", 32'(ovf_w[sel]), 32'(eo));
    prev_s[sel] = es;
  endtask

  task automatic do_op_exp(input int sel, input bit sub, input int a, input int b,
                           input bit cin, input logic [7:0] es, input bit ec, input bit eo);
    launch(sel, sub, a, b, cin);
    wait_done(sel, n_of[sel], es, ec, eo);
  endtask

  task automatic do_op(input int sel, input bit sub, input int a, input int b, input bit cin);
    logic [7:0] es;
    logic       ec, eo;
    model(w_of[sel], sub, a, b, cin, es, ec, eo);
    do_op_exp(sel, sub, a, b, cin, es, ec, eo);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    start_r = 1'b0;
    sub_r   = 1'b0;
    cin_r   = 1'b0;
    a_r     = '0;
    b_r     = '0;
    sel_r   = 0;
    cur_sel = 0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      cur_sel = d;
      check("rst_busy", 32'(busy_w[d]), 32'd0);
      check("rst_done", 32'(done_w[d]), 32'd0);
      check("rst_s", {24'h0, s_w[d]}, 32'd0);
      check("rst_cout", 32'(cout_w[d]), 32'd0);
      check("rst_ovf", 32'(ovf_w[d]), 32'd0);
      prev_s[d] = '0;
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed 8-bit serial cases, the first followed by a return to IDLE.
    do_op_exp(0, 1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    @(negedge clk);
    check("done_pulse_end", 32'(done_w[0]), 32'd0);
    check("idle_busy", 32'(busy_w[0]), 32'd0);
    do_op_exp(0, 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    do_op_exp(0, 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op_exp(0, 1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
    do_op_exp(0, 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);

    // STEP=4 directed case, then back-to-back random operations.
    do_op_exp(1, 1'b0, 8'h3C, 8'h4D, 1'b1, 8'h8A, 1'b0, 1'b1);
    for (int k = 0; k < 30; k++)
      do_op(1, 1'($urandom), int'($urandom_range(255)), int'($urandom_range(255)), 1'($urandom));

    // START mid-RUN with different operands must be ignored.
    @(negedge clk);
    launch(0, 1'b0, 8'h12, 8'h34, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a_r     = 8'hFF;
    b_r     = 8'hFF;
    sub_r   = 1'b1;
    cin_r   = 1'b1;
    start_r = 1'b1;
    @(posedge clk);
    #1;
    start_r = 1'b0;
    wait_done(0, n_of[0] - 2, 8'h46, 1'b0, 1'b0);

    // Asynchronous reset in the third RUN cycle.
    @(negedge clk);
    launch(0, 1'b0, 8'h55, 8'h22, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(busy_w[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy_w[0]), 32'd0);
    check("arst_done", 32'(done_w[0]), 32'd0);
    check("arst_s", {24'h0, s_w[0]}, 32'd0);
    check("arst_cout", 32'(cout_w[0]), 32'd0);
    check("arst_ovf", 32'(ovf_w[0]), 32'd0);
    for (int d = 0; d < 4; d++) prev_s[d] = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("no_done_after_rst", 32'(done_w[0]), 32'd0);
    end
    do_op(0, 1'b0, 8'h55, 8'h22, 1'b0);

    // Random 8-bit serial operations.
    for (int k = 0; k < 30; k++)
      do_op(0, 1'($urandom), int'($urandom_range(255)), int'($urandom_range(255)), 1'($urandom));

    // Exhaustive 4-bit sweeps for STEP=1 and STEP=2.
    for (int d = 2; d < 4; d++)
      for (int sb = 0; sb < 2; sb++)
        for (int ci = 0; ci < 2; ci++)
          for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
              do_op(d, 1'(sb), a, b, 1'(ci));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
